// File: rtl/booth_sequencer.sv
// Radix-2 Booth multiply sequencer: drives a shared 2N-bit adder one add/sub/skip step per clock.
// Define BOOTH_SKIP_EN to finish early once every remaining step would be a skip.
module booth_sequencer #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [2*N-1:0] add_i0,
    output logic [2*N-1:0] add_onescomp,
    output logic           add_cin,
    input  logic [2*N-1:0] add_sum
);

    localparam int W  = 2 * N;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [W-1:0]    p;
    logic [W-1:0]    ms;
    logic [N-1:0]    qr;
    logic            qp;
    logic [SW-1:0]   step;
    logic [N-1:0]    qr_next;
    logic            last_step;

    assign qr_next = {qr[N-1], qr[N-1:1]};

`ifdef BOOTH_SKIP_EN
    // Once the shifted multiplier is all copies of the new qp, every pending step is a skip.
    assign last_step = (step == SW'(N - 1)) || (qr_next == {N{qr[0]}});
`else
    assign last_step = (step == SW'(N - 1));
`endif

    // Adder operands are decoded from the registers so the sum can be captured at the same edge.
    always_comb begin
        add_i0       = '0;
        add_onescomp = '0;
        add_cin      = 1'b0;
        if (state == RUN) begin
            add_i0 = p;
            case ({qr[0], qp})
                2'b01: add_onescomp = ms;
                2'b10: begin
                    add_onescomp = ~ms;
                    add_cin      = 1'b1;
                end
                default: add_onescomp = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            p       <= '0;
            ms      <= '0;
            qr      <= '0;
            qp      <= 1'b0;
            step    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        p     <= '0;
                        ms    <= {{N{multiplicand[N-1]}}, multiplicand};
                        qr    <= multiplier;
                        qp    <= 1'b0;
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    p    <= add_sum;
                    ms   <= ms << 1;
                    qp   <= qr[0];
                    qr   <= qr_next;
                    step <= step + 1'b1;
                    if (last_step) begin
                        product <= add_sum;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_sequencer.sv
// Self-checking bench for booth_sequencer (N=32) with a behavioural model of the shared adder.
// Step counts follow BOOTH_SKIP_EN when the bench is built with that macro.
module tb_booth_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [63:0] add_i0;
    logic [63:0] add_onescomp;
    logic        add_cin;
    logic [63:0] add_sum;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    typedef struct {
        logic [31:0] m;
        logic [31:0] q;
        logic [63:0] prod;
        int          lenFull;
        int          lenSkip;
    } vec_t;

    vec_t vecs[9];

    booth_sequencer #(.N(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .product(product),
        .add_i0(add_i0), .add_onescomp(add_onescomp), .add_cin(add_cin),
        .add_sum(add_sum)
    );

    assign add_sum = add_i0 + add_onescomp + 64'(add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        logic [63:0] exp;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: done seen with no expected product queued");
        end else begin
            exp = sb.pop_front();
            check64("product", product, exp);
        end
    endtask

    // Runs one operation, optionally poking start during RUN and during DONE.
    task automatic applyStimulus(input logic [31:0] m, input logic [31:0] q,
                                 input logic [63:0] expProd, input int expL,
                                 input bit pulseRun, input bit pulseDone,
                                 output logic [31:0] cinMask);
        int busyCnt;
        int doneAt;
        busyCnt = 0;
        doneAt  = 0;
        cinMask = '0;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        sb.push_back(expProd);
        @(negedge clk);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        for (int k = 1; k <= 100; k++) begin
            if (busy) begin
                busyCnt++;
                if (add_cin && k <= 32) cinMask[k-1] = 1'b1;
            end
            if (done) begin
                doneAt = k;
                break;
            end
            start = pulseRun && (k == 3);
            @(negedge clk);
        end
        start = 1'b0;
        if (doneAt == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done expected done at cycle %0d", expL + 1);
            void'(sb.pop_front());
        end else begin
            checkOutput();
        end
        check64("done_latency", 64'(doneAt), 64'(expL + 1));
        check64("busy_cycles", 64'(busyCnt), 64'(expL));
        start = pulseDone;
        @(negedge clk);
        start = 1'b0;
        check64("done_single_pulse", 64'(done), 64'd0);
        check64("product_held", product, expProd);
        @(negedge clk);
        check64("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] mask;
        vecs[0] = '{32'd3,        32'd5,        64'h000000000000000F, 32, 4};
        vecs[1] = '{32'hFFFFFFF9, 32'd6,        64'hFFFFFFFFFFFFFFD6, 32, 4};
        vecs[2] = '{32'h80000000, 32'h80000000, 64'h4000000000000000, 32, 32};
        vecs[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF80000001, 32, 1};
        vecs[4] = '{32'd9,        32'd0,        64'h0000000000000000, 32, 1};
        vecs[5] = '{32'd9,        32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFF7, 32, 1};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 32, 1};
        vecs[7] = '{32'd2,        32'h00001000, 64'h0000000000002000, 32, 14};
        vecs[8] = '{32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000, 32, 32};

        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(negedge clk);
        check64("reset_busy", 64'(busy), 64'd0);
        check64("reset_done", 64'(done), 64'd0);
        check64("reset_product", product, 64'd0);
        check64("reset_add_i0", add_i0, 64'd0);
        check64("reset_add_onescomp", add_onescomp, 64'd0);
        check64("reset_add_cin", 64'(add_cin), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
`ifdef BOOTH_SKIP_EN
            applyStimulus(vecs[i].m, vecs[i].q, vecs[i].prod, vecs[i].lenSkip, 1'b0, 1'b0, mask);
`else
            applyStimulus(vecs[i].m, vecs[i].q, vecs[i].prod, vecs[i].lenFull, 1'b0, 1'b0, mask);
`endif
            // -7 x 6 subtracts only on step 1 (multiplier bits 1,0 = 1,0)
            if (i == 1) check64("cin_subtract_steps", 64'(mask), 64'h2);
        end

        // start pokes during RUN and DONE must not disturb the operation in flight
`ifdef BOOTH_SKIP_EN
        applyStimulus(32'd3, 32'd5, 64'hF, 4, 1'b1, 1'b1, mask);
`else
        applyStimulus(32'd3, 32'd5, 64'hF, 32, 1'b1, 1'b1, mask);
`endif

        // reset asserted at step 10 of an operation
        @(negedge clk);
        multiplicand = 32'd3;
        multiplier   = 32'd5;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check64("midrst_busy", 64'(busy), 64'd0);
        check64("midrst_done", 64'(done), 64'd0);
        check64("midrst_product", product, 64'd0);
        check64("midrst_add_i0", add_i0, 64'd0);
        check64("midrst_add_onescomp", add_onescomp, 64'd0);
        check64("midrst_add_cin", 64'(add_cin), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check64("post_rst_no_done", 64'(done), 64'd0);
        end
`ifdef BOOTH_SKIP_EN
        applyStimulus(32'd3, 32'd5, 64'hF, 4, 1'b0, 1'b0, mask);
`else
        applyStimulus(32'd3, 32'd5, 64'hF, 32, 1'b0, 1'b0, mask);
`endif
        check64("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_sequencer.md
# booth_sequencer

Multi-cycle controller that computes a signed N×N radix-2 Booth product by sequencing the shared 2N-bit adder/subtractor: one add, subtract or skip step per clock. It sits between the multiplier's request interface and the combinational `sixtyFourBitAdderSubtractor` instance (N=32). It owns the operand, accumulator and step-count registers, and drives the adder's `i0`, `onesComp_ip` and `cin`, taking `sum` back in the same cycle.

## Interface
- `N`, default 32: operand width; the adder and product width is 2N.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request. Sampled only in IDLE; ignored in RUN and DONE.
- `multiplicand`  in  N: signed two's-complement operand M. Captured when start is accepted.
- `multiplier`  in  N: signed two's-complement operand Q. Captured when start is accepted.
- `busy`  out  1: high while in RUN.
- `done`  out  1: single-cycle pulse in DONE.
- `product`  out  2N: signed M×Q. Registered, and held until the next completion.
- `add_i0`  out  2N: adder input `i0`. Driven with accumulator P in RUN, 0 otherwise.
- `add_onescomp`  out  2N: adder input `onesComp_ip`. Driven with Ms, ~Ms or 0 in RUN, 0 otherwise.
- `add_cin`  out  1: adder carry-in. 1 only on a subtract step.
- `add_sum`  in  2N: adder `sum`, combinational from the `add_*` inputs.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on start.
  - RUN → DONE after the last step.
  - DONE → IDLE unconditionally.
- Accept edge (IDLE and start=1):
  - P ← 0.
  - Ms ← sign-extend(M) to 2N.
  - Qr ← Q.
  - qp ← 0.
  - step ← 0.
- Each RUN cycle, decode {Qr[0], qp}:
  - 01: add. add_onescomp=Ms, cin=0.
  - 10: subtract. add_onescomp=~Ms, cin=1.
  - 00/11: skip. add_onescomp=0, cin=0.
- add_i0=P in every RUN cycle.
- Each RUN edge:
  - P ← add_sum.
  - Ms ← Ms<<1.
  - qp ← Qr[0].
  - Qr ← Qr>>>1 (arithmetic).
  - step ← step+1.
- Last step is the one where step==N-1 (early termination per Configuration).
- Entering DONE: product ← final add_sum.
- Arithmetic is modulo 2^2N. The adder carry-out is neither used nor needed; the result is exact for all signed N-bit operands.
- start held high continuously: a new operation is accepted in the IDLE cycle that follows each DONE.
- Operand inputs may change freely after the accept edge.

## Timing
- Reset values:
  - busy=0, done=0, product=0.
  - add_i0=0, add_onescomp=0, add_cin=0.
  - State IDLE; P, Ms, Qr, qp and step all 0.
- Reset mid-operation: immediate return to IDLE with all of the above values. No done pulse and no product update.
- Latency: L = number of RUN steps (N by default).
  - busy is high for exactly L cycles, starting the cycle after the accept edge.
  - done is high the cycle after the last RUN cycle, L+1 cycles after the accept edge, for exactly 1 cycle.
  - product is valid in the done cycle and stable until the next done.
- Adder path: `add_*` outputs are decoded from registers, and add_sum is captured at the same edge. There is one combinational adder delay per cycle.
- Throughput: one operation per L+2 cycles (IDLE, L×RUN, DONE).

## Configuration
- `BOOTH_SKIP_EN` defined: early termination.
  - After each RUN edge, if every bit of the new Qr equals the new qp, the remaining steps would all be skips. The FSM moves to DONE, and product takes that edge's add_sum.
  - L ranges from 1 to N.
  - Multiplier 0 or −1: L=1.
- `BOOTH_SKIP_EN` undefined:
  - L=N always.
  - No comparison logic is present.

## Test plan
- Reset, then start with M=3, Q=5 (N=32):
  - busy is high for 32 cycles.
  - done rises 33 cycles after the accept edge.
  - product=0x000000000000000F.
- M=0xFFFFFFF9 (−7), Q=6 → product=0xFFFFFFFFFFFFFFD6 (−42). Check add_cin=1 exactly on the subtract steps.
- Corner values:
  - M=Q=0x80000000 → product=0x4000000000000000.
  - M=0x7FFFFFFF, Q=0xFFFFFFFF → product=0xFFFFFFFF80000001.
- Start pulse during RUN and during DONE: both ignored, and the result is unchanged.
- Assert rst at step 10: busy=0, product=0 and `add_*`=0 immediately. The next 3×5 operation completes correctly.
- With `BOOTH_SKIP_EN`:
  - 3×5: done 5 cycles after accept (L=4), product=15.
  - 9×0: done 2 cycles after accept (L=1), product=0.
  - 9×−1: done 2 cycles after accept (L=1), product=0xFFFFFFFFFFFFFFF7.
